// File: rtl/lbp_engine_param_if.sv
// lbp_engine_param_if: bundles the controller handshake (start/busy/finish),
// the gray-memory read port and the LBP-memory write port of the LBP engine.
// master = engine side, slave = controller/memory side.
interface lbp_engine_param_if #(
  parameter int ADDR_W = 6,
  parameter int PIX_W  = 8
);
  logic              start;
  logic              busy;
  logic              finish;
  logic              gray_req;
  logic [ADDR_W-1:0] gray_addr;
  logic [PIX_W-1:0]  gray_data;
  logic              lbp_write;
  logic [ADDR_W-1:0] lbp_addr;
  logic [7:0]        lbp_data;
  logic              lbp_uniform;

  modport master (
    input  start, gray_data,
    output busy, finish, gray_req, gray_addr,
           lbp_write, lbp_addr, lbp_data, lbp_uniform
  );

  modport slave (
    output start, gray_data,
    input  busy, finish, gray_req, gray_addr,
           lbp_write, lbp_addr, lbp_data, lbp_uniform
  );
endinterface

// File: rtl/lbp_engine_param.sv
// lbp_engine_param: streams 3x3 windows out of a row-major gray memory
// (1-cycle read latency), one column (top, mid, bottom) at a time, and writes
// one 8-bit LBP code per interior pixel. BORDER_MODE=1 appends 0x00 writes to
// every border address. Optional macro LBP_UNIFORM_EN adds the uniform flag.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | after reset, waiting for start
// FILL    | reading columns 0 and 1 of rows r-1..r+1
// RUN     | reading column c+1, one LBP write per column
// DRAIN   | last read issued, waiting for the final interior write
// BORDER  | one 0x00 write per cycle to each border address
// DONE    | frame complete, finish held until the next start
module lbp_engine_param #(
  parameter int IMG_W       = 8,
  parameter int IMG_H       = 8,
  parameter int PIX_W       = 8,
  parameter int ADDR_W      = 6,
  parameter int BORDER_MODE = 0
) (
  input  logic                clk,
  input  logic                reset,
  lbp_engine_param_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_RUN, S_DRAIN, S_BORDER, S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] W_A      = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(IMG_W - 1);
  localparam logic [ADDR_W-1:0] LAST_MID = ADDR_W'(IMG_H - 2);
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(IMG_H - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic [ADDR_W-1:0] col_q, col_d;
  logic [1:0]        sel_q, sel_d;
  logic              finish_q, finish_d;
  logic              gray_req;
  logic [ADDR_W-1:0] rd_row;

  // read in flight: describes the data arriving on gray_data this cycle
  logic              rd_vld_q, rd_vld_d;
  logic [1:0]        rd_sel_q, rd_sel_d;
  logic              rd_wr_q, rd_wr_d;
  logic [ADDR_W-1:0] rd_waddr_q, rd_waddr_d;

  logic [PIX_W-1:0]  win_q [3][3];
  logic [PIX_W-1:0]  win_d [3][3];
  logic [PIX_W-1:0]  hold_t_q, hold_t_d;
  logic [PIX_W-1:0]  hold_m_q, hold_m_d;
  logic [7:0]        code;

  logic              wr_fire;
  logic              bord;
  logic              lbp_write_q, lbp_write_d;
  logic [ADDR_W-1:0] lbp_addr_q, lbp_addr_d;
  logic [7:0]        lbp_data_q, lbp_data_d;

  // FSM next state, scan counters and read strobe
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    sel_d    = sel_q;
    gray_req = 1'b0;
    finish_d = (state_q == S_DONE) && !bus.start;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_FILL;
          row_d   = ADDR_W'(1);
          col_d   = '0;
          sel_d   = 2'd0;
        end
      end
      S_FILL: begin
        gray_req = 1'b1;
        if (sel_q == 2'd2) begin
          sel_d = 2'd0;
          if (col_q == ADDR_W'(1)) begin
            col_d   = ADDR_W'(2);
            state_d = S_RUN;
          end else begin
            col_d = col_q + ADDR_W'(1);
          end
        end else begin
          sel_d = sel_q + 2'd1;
        end
      end
      S_RUN: begin
        gray_req = 1'b1;
        if (sel_q == 2'd2) begin
          sel_d = 2'd0;
          if (col_q == LAST_COL) begin
            col_d = '0;
            if (row_q == LAST_MID) begin
              state_d = S_DRAIN;
            end else begin
              row_d   = row_q + ADDR_W'(1);
              state_d = S_FILL;
            end
          end else begin
            col_d = col_q + ADDR_W'(1);
          end
        end else begin
          sel_d = sel_q + 2'd1;
        end
      end
      S_DRAIN: begin
        // nothing in flight and the last write on the bus: it retires now
        if (!rd_vld_q && lbp_write_q) begin
          if (BORDER_MODE == 1) begin
            state_d = S_BORDER;
            row_d   = '0;
            col_d   = '0;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_BORDER: begin
        if (row_q == '0 || row_q == LAST_ROW) begin
          if (col_q == LAST_COL) begin
            if (row_q == LAST_ROW) begin
              state_d = S_DONE;
            end else begin
              row_d = row_q + ADDR_W'(1);
              col_d = '0;
            end
          end else begin
            col_d = col_q + ADDR_W'(1);
          end
        end else if (col_q == '0) begin
          col_d = LAST_COL;
        end else begin
          row_d = row_q + ADDR_W'(1);
          col_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // read address and tags for the read being issued
  always_comb begin
    rd_row     = row_q + ADDR_W'(sel_q) - ADDR_W'(1);
    rd_vld_d   = gray_req;
    rd_sel_d   = sel_q;
    rd_wr_d    = (state_q == S_RUN);
    rd_waddr_d = row_q * W_A + col_q - ADDR_W'(1);
  end

  // capture returning pixels; a bottom pixel completes a column and shifts the window
  always_comb begin
    hold_t_d = hold_t_q;
    hold_m_d = hold_m_q;
    win_d    = win_q;
    if (rd_vld_q) begin
      case (rd_sel_q)
        2'd0: hold_t_d = bus.gray_data;
        2'd1: hold_m_d = bus.gray_data;
        default: begin
          for (int i = 0; i < 3; i++) begin
            win_d[i][0] = win_q[i][1];
            win_d[i][1] = win_q[i][2];
          end
          win_d[0][2] = hold_t_q;
          win_d[1][2] = hold_m_q;
          win_d[2][2] = bus.gray_data;
        end
      endcase
    end
  end

  // LBP code from the window as it will look after this cycle's shift
  always_comb begin
    code[0] = win_d[0][0] >= win_d[1][1];
    code[1] = win_d[0][1] >= win_d[1][1];
    code[2] = win_d[0][2] >= win_d[1][1];
    code[3] = win_d[1][0] >= win_d[1][1];
    code[4] = win_d[1][2] >= win_d[1][1];
    code[5] = win_d[2][0] >= win_d[1][1];
    code[6] = win_d[2][1] >= win_d[1][1];
    code[7] = win_d[2][2] >= win_d[1][1];
  end

  // write port: interior codes from the pipeline, zeros during BORDER
  always_comb begin
    wr_fire     = rd_vld_q && (rd_sel_q == 2'd2) && rd_wr_q;
    bord        = (state_q == S_BORDER);
    lbp_write_d = wr_fire || bord;
    lbp_addr_d  = lbp_addr_q;
    lbp_data_d  = lbp_data_q;
    if (wr_fire) begin
      lbp_addr_d = rd_waddr_q;
      lbp_data_d = code;
    end else if (bord) begin
      lbp_addr_d = row_q * W_A + col_q;
      lbp_data_d = 8'h00;
    end
  end

  // control and pipeline registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      sel_q       <= 2'd0;
      finish_q    <= 1'b0;
      rd_vld_q    <= 1'b0;
      rd_sel_q    <= 2'd0;
      rd_wr_q     <= 1'b0;
      rd_waddr_q  <= '0;
      hold_t_q    <= '0;
      hold_m_q    <= '0;
      lbp_write_q <= 1'b0;
      lbp_addr_q  <= '0;
      lbp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      sel_q       <= sel_d;
      finish_q    <= finish_d;
      rd_vld_q    <= rd_vld_d;
      rd_sel_q    <= rd_sel_d;
      rd_wr_q     <= rd_wr_d;
      rd_waddr_q  <= rd_waddr_d;
      hold_t_q    <= hold_t_d;
      hold_m_q    <= hold_m_d;
      lbp_write_q <= lbp_write_d;
      lbp_addr_q  <= lbp_addr_d;
      lbp_data_q  <= lbp_data_d;
    end
  end

  // 3x3 window registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          win_q[i][j] <= '0;
        end
      end
    end else begin
      win_q <= win_d;
    end
  end

`ifdef LBP_UNIFORM_EN
  logic [7:0] ring;
  logic [7:0] ring_diff;
  logic       uni_calc;
  logic       lbp_uniform_q, lbp_uniform_d;

  // transitions around the circle TL,T,TR,R,BR,B,BL,L back to TL
  always_comb begin
    ring          = {code[3], code[5], code[6], code[7], code[4], code[2], code[1], code[0]};
    ring_diff     = ring ^ {ring[0], ring[7:1]};
    uni_calc      = ($countones(ring_diff) <= 2);
    lbp_uniform_d = lbp_uniform_q;
    if (wr_fire) begin
      lbp_uniform_d = uni_calc;
    end else if (bord) begin
      lbp_uniform_d = 1'b1;
    end
  end

  // uniform flag registered alongside lbp_data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lbp_uniform_q <= 1'b0;
    end else begin
      lbp_uniform_q <= lbp_uniform_d;
    end
  end

  assign bus.lbp_uniform = lbp_uniform_q;
`else
  assign bus.lbp_uniform = 1'b0;
`endif

  assign bus.busy      = (state_q != S_IDLE) && !finish_q;
  assign bus.finish    = finish_q;
  assign bus.gray_req  = gray_req;
  assign bus.gray_addr = gray_req ? (rd_row * W_A + col_q) : '0;
  assign bus.lbp_write = lbp_write_q;
  assign bus.lbp_addr  = lbp_addr_q;
  assign bus.lbp_data  = lbp_data_q;

endmodule

// File: tb/tb_lbp_engine_param.sv
// Scoreboard bench for lbp_engine_param: a 10x6 frame with border writes.
// Expected writes come from a reference LBP model over the bench image.
module tb_lbp_engine_param;
  localparam int W  = 10;
  localparam int H  = 6;
  localparam int AW = 6;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
    logic          uni;
  } wr_t;

  logic clk;
  logic reset;
  logic [7:0] img [W*H];
  wr_t  exp_q [$];

  int n_chk   = 0;
  int n_pass  = 0;
  int rd_cnt  = 0;
  int wr_cnt  = 0;
  int req_falls = 0;
  logic req_prev = 1'b0;
  logic want_first = 1'b0;
  int first_addr = -1;

  lbp_engine_param_if #(.ADDR_W(AW), .PIX_W(8)) bus ();

  lbp_engine_param #(
    .IMG_W(W), .IMG_H(H), .PIX_W(8), .ADDR_W(AW), .BORDER_MODE(1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // gray memory with 1-cycle read latency
  always @(posedge clk) begin
    if (bus.gray_req && int'(bus.gray_addr) < W*H) bus.gray_data <= img[int'(bus.gray_addr)];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // advance one cycle and observe DUT outputs on the falling edge
  task automatic tick();
    wr_t e;
    @(negedge clk);
    if (reset) begin
      if (bus.gray_req) begin
        rd_cnt++;
        if (want_first) begin
          first_addr = int'(bus.gray_addr);
          want_first = 1'b0;
        end
      end
      if (req_prev && !bus.gray_req) req_falls++;
      req_prev = bus.gray_req;
      if (bus.lbp_write) begin
        wr_cnt++;
        chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("wr_addr", 32'(bus.lbp_addr), 32'(e.addr));
          chk("wr_data", 32'(bus.lbp_data), 32'(e.data));
          chk("wr_uniform", 32'(bus.lbp_uniform), 32'(e.uni));
        end
      end
    end else begin
      req_prev = 1'b0;
    end
  endtask

  function automatic logic [7:0] lbp_ref(input int r, input int c);
    int dr [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
    int dc [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
    logic [7:0] code;
    logic [7:0] ctr;
    ctr = img[r*W + c];
    for (int b = 0; b < 8; b++) code[b] = img[(r + dr[b])*W + c + dc[b]] >= ctr;
    return code;
  endfunction

`ifdef LBP_UNIFORM_EN
  function automatic logic uni_ref(input logic [7:0] code);
    int ring [8] = '{0, 1, 2, 4, 7, 6, 5, 3};
    int n = 0;
    for (int i = 0; i < 8; i++) if (code[ring[i]] != code[ring[(i + 1) % 8]]) n++;
    return n <= 2;
  endfunction
`endif

  task automatic fill_img(input int pat);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        case (pat)
          0: img[r*W + c] = 8'd100;
          1: img[r*W + c] = 8'(c * 10);
          2: img[r*W + c] = ((r + c) % 2 == 1) ? 8'd200 : 8'd0;
          3: img[r*W + c] = 8'($urandom_range(0, 255));
          default: img[r*W + c] = 8'($urandom_range(0, 3));
        endcase
      end
    end
  endtask

  task automatic build_exp();
    wr_t e;
    exp_q.delete();
    for (int r = 1; r < H - 1; r++) begin
      for (int c = 1; c < W - 1; c++) begin
        e.addr = AW'(r*W + c);
        e.data = lbp_ref(r, c);
`ifdef LBP_UNIFORM_EN
        e.uni = uni_ref(e.data);
`else
        e.uni = 1'b0;
`endif
        exp_q.push_back(e);
      end
    end
    for (int a = 0; a < W*H; a++) begin
      if (a / W == 0 || a / W == H - 1 || a % W == 0 || a % W == W - 1) begin
        e.addr = AW'(a);
        e.data = 8'h00;
`ifdef LBP_UNIFORM_EN
        e.uni = 1'b1;
`else
        e.uni = 1'b0;
`endif
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic run_frame(input int pat, input bit mid_start);
    int n_exp, rd_base, wr_base, fall_base, t;
    fill_img(pat);
    build_exp();
    n_exp = exp_q.size();
    rd_base = rd_cnt;
    wr_base = wr_cnt;
    fall_base = req_falls;
    want_first = 1'b1;
    first_addr = -1;
    pulse_start();
    chk("busy_after_start", 32'(bus.busy), 32'd1);
    chk("finish_after_start", 32'(bus.finish), 32'd0);
    if (mid_start) begin
      repeat (20) tick();
      pulse_start();
    end
    t = 0;
    while (!bus.finish && t < 3000) begin
      tick();
      t++;
    end
    chk("finish_seen", 32'(bus.finish), 32'd1);
    chk("busy_at_finish", 32'(bus.busy), 32'd0);
    chk("write_count", 32'(wr_cnt - wr_base), 32'(n_exp));
    chk("read_count", 32'(rd_cnt - rd_base), 32'(3*W*(H-2)));
    chk("req_contiguous", 32'(req_falls - fall_base), 32'd1);
    chk("first_read_addr", 32'(first_addr), 32'd0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    repeat (2) tick();
    chk("finish_held", 32'(bus.finish), 32'd1);
    chk("addr_hold", 32'(bus.lbp_addr), 32'(W*H - 1));
    chk("data_hold", 32'(bus.lbp_data), 32'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_finish"}, 32'(bus.finish), 32'd0);
    chk({tag, "_gray_req"}, 32'(bus.gray_req), 32'd0);
    chk({tag, "_gray_addr"}, 32'(bus.gray_addr), 32'd0);
    chk({tag, "_lbp_write"}, 32'(bus.lbp_write), 32'd0);
    chk({tag, "_lbp_addr"}, 32'(bus.lbp_addr), 32'd0);
    chk({tag, "_lbp_data"}, 32'(bus.lbp_data), 32'd0);
    chk({tag, "_lbp_uniform"}, 32'(bus.lbp_uniform), 32'd0);
  endtask

  initial begin
    int t, wr_base, rd_base;
    reset = 1'b0;
    bus.start = 1'b0;
    bus.gray_data = '0;
    for (int i = 0; i < W*H; i++) img[i] = 8'd0;
    repeat (3) tick();
    check_outputs_zero("reset");
    reset = 1'b1;
    repeat (2) tick();

    run_frame(0, 1'b0);
    run_frame(1, 1'b0);
    run_frame(2, 1'b1);
    run_frame(3, 1'b0);
    run_frame(4, 1'b0);

    // abort during RUN of row 3, then a fresh frame
    fill_img(3);
    build_exp();
    wr_base = wr_cnt;
    pulse_start();
    t = 0;
    while ((wr_cnt - wr_base) < 2*(W-2) + 2 && t < 2000) begin
      tick();
      t++;
    end
    chk("reached_row3", 32'((wr_cnt - wr_base) >= 2*(W-2) + 2), 32'd1);
    reset = 1'b0;
    #1;
    check_outputs_zero("abort");
    tick();
    exp_q.delete();
    tick();
    reset = 1'b1;
    wr_base = wr_cnt;
    rd_base = rd_cnt;
    repeat (4) tick();
    chk("no_write_after_abort", 32'(wr_cnt - wr_base), 32'd0);
    chk("no_read_after_abort", 32'(rd_cnt - rd_base), 32'd0);
    chk("idle_after_abort", 32'(bus.busy), 32'd0);
    run_frame(3, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
